// File: rtl/cla_nibble_serial_adder_pkg.sv
// cla_pkg: shared constants, FSM encoding and width legality check for the nibble-serial adder
package cla_pkg;
  localparam int NIBBLE_W = 4;
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;
  function automatic bit width_ok(input int w);
    return (w >= 2 * NIBBLE_W) && (w % NIBBLE_W == 0);
  endfunction
endpackage

// File: rtl/cla_nibble_serial_adder_cla4_slice.sv
// cla4_slice: combinational 4-bit carry-lookahead adder with carry-in
module cla4_slice
  import cla_pkg::*;
(
  input  logic [NIBBLE_W-1:0] a,
  input  logic [NIBBLE_W-1:0] b,
  input  logic                cin,
  output logic [NIBBLE_W-1:0] sum,
  output logic                cout
);
  logic [NIBBLE_W-1:0] w_g, w_p;
  logic [NIBBLE_W:1]   w_c;
  assign w_g = a & b;
  assign w_p = a ^ b;
  assign w_c[1] = w_g[0] | (w_p[0] & cin);
  assign w_c[2] = w_g[1] | (w_p[1] & w_g[0]) | (w_p[1] & w_p[0] & cin);
  assign w_c[3] = w_g[2] | (w_p[2] & w_g[1]) | (w_p[2] & w_p[1] & w_g[0])
                | (w_p[2] & w_p[1] & w_p[0] & cin);
  assign w_c[4] = w_g[3] | (w_p[3] & w_g[2]) | (w_p[3] & w_p[2] & w_g[1])
                | (w_p[3] & w_p[2] & w_p[1] & w_g[0])
                | (w_p[3] & w_p[2] & w_p[1] & w_p[0] & cin);
  assign sum  = w_p ^ {w_c[3:1], cin};
  assign cout = w_c[4];
endmodule

// File: rtl/cla_nibble_serial_adder.sv
// cla_nibble_serial_adder: WIDTH-bit add/subtract using one 4-bit CLA slice, one nibble per cycle
module cla_nibble_serial_adder
  import cla_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             overflow
);
  localparam int NIBBLES = WIDTH / NIBBLE_W;
  localparam int IDX_W = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;
  localparam logic [IDX_W-1:0] LAST = IDX_W'(NIBBLES - 1);
  if (!width_ok(WIDTH)) begin : g_bad_width
    $error("WIDTH must be a multiple of 4 and at least 8");
  end
  state_t                             r_state, w_next;
  logic [IDX_W-1:0]                   r_idx;
  logic [NIBBLES-1:0][NIBBLE_W-1:0]   r_opa, r_opb, r_sum;
  logic                               r_carry, r_cout, r_ovf;
  logic [NIBBLE_W-1:0]                w_s;
  logic                               w_c, w_last, w_accept;
  cla4_slice u_slice (
    .a   (r_opa[r_idx]),
    .b   (r_opb[r_idx]),
    .cin (r_carry),
    .sum (w_s),
    .cout(w_c)
  );
  assign in_ready  = r_state == ST_IDLE;
  assign out_valid = r_state == ST_DONE;
  assign w_accept  = in_ready && in_valid;
  assign w_last    = r_idx == LAST;
  assign sum       = r_sum;
  assign cout      = r_cout;
  assign overflow  = r_ovf;
  always_comb begin
    w_next = r_state;
    w_next = w_accept                                ? ST_RUN  :
             (r_state == ST_RUN && w_last)           ? ST_DONE :
             (r_state == ST_DONE && out_ready)       ? ST_IDLE : r_state;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= ST_IDLE;
      r_idx   <= '0;
      r_carry <= 1'b0;
      r_opa   <= '0;
      r_opb   <= '0;
      r_sum   <= '0;
      r_cout  <= 1'b0;
      r_ovf   <= 1'b0;
    end else begin
      r_state <= w_next;
      if (w_accept) begin
        r_opa   <= a;
        r_opb   <= sub ? ~b : b;
        r_carry <= sub | cin;
        r_idx   <= '0;
      end else if (r_state == ST_RUN) begin
        r_sum[r_idx] <= w_s;
        r_carry      <= w_c;
        if (!w_last) r_idx <= r_idx + 1'b1;
        if (w_last) begin
          r_cout <= w_c;
          // overflow uses the already-inverted operand B for subtracts
          r_ovf  <= (r_opa[NIBBLES-1][NIBBLE_W-1] == r_opb[NIBBLES-1][NIBBLE_W-1])
                 && (w_s[NIBBLE_W-1] != r_opa[NIBBLES-1][NIBBLE_W-1]);
        end
      end
    end
  end
endmodule

// File: tb/tb_cla_nibble_serial_adder.sv
// tb_cla_nibble_serial_adder: directed and random checks against an integer-arithmetic model
module tb_cla_nibble_serial_adder;
  localparam int W = 16;
  localparam int N = W / 4;
  logic clk = 1'b0;
  logic rst, in_valid, out_ready, cin, sub;
  logic [W-1:0] a, b, sum;
  logic in_ready, out_valid, cout, overflow;
  int n_checks = 0;
  int n_errors = 0;
  always #5 clk = ~clk;
  cla_nibble_serial_adder #(.WIDTH(W)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .cin(cin), .sub(sub),
    .out_valid(out_valid), .out_ready(out_ready),
    .sum(sum), .cout(cout), .overflow(overflow)
  );
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  // returns {overflow, cout, sum} from plain signed/unsigned integer arithmetic
  function automatic logic [17:0] ref_op(input logic [15:0] x, input logic [15:0] y,
                                         input logic ci, input logic s);
    int sx, sy, sr, ur;
    logic c;
    sx = int'($signed(x));
    sy = int'($signed(y));
    sr = s ? sx - sy : sx + sy + int'(ci);
    ur = s ? int'(x) - int'(y) : int'(x) + int'(y) + int'(ci);
    c  = s ? (x >= y) : (ur > 65535);
    return {(sr > 32767) || (sr < -32768), c, 16'(ur)};
  endfunction
  task automatic wait_valid(output int k);
    k = 0;
    while (!out_valid && k < 20) begin
      step();
      k++;
    end
  endtask
  task automatic check_result(input string tag, input logic [17:0] e);
    chk({tag, "/sum"}, 32'(sum), 32'(e[15:0]));
    chk({tag, "/cout"}, 32'(cout), 32'(e[16]));
    chk({tag, "/ovf"}, 32'(overflow), 32'(e[17]));
  endtask
  task automatic run_op(input logic [15:0] x, input logic [15:0] y,
                        input logic ci, input logic s, input string tag);
    logic [17:0] e;
    int k;
    e = ref_op(x, y, ci, s);
    a = x; b = y; cin = ci; sub = s; in_valid = 1'b1;
    chk({tag, "/in_ready_idle"}, 32'(in_ready), 32'd1);
    step();
    in_valid = 1'b0;
    chk({tag, "/in_ready_run"}, 32'(in_ready), 32'd0);
    wait_valid(k);
    chk({tag, "/latency"}, 32'(k), 32'(N));
    chk({tag, "/in_ready_done"}, 32'(in_ready), 32'd0);
    check_result(tag, e);
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    chk({tag, "/out_valid_drop"}, 32'(out_valid), 32'd0);
    chk({tag, "/in_ready_back"}, 32'(in_ready), 32'd1);
  endtask
  initial begin
    logic [17:0] e;
    int k;
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; cin = 1'b0; sub = 1'b0; a = '0; b = '0;
    step();
    step();
    rst = 1'b0;
    chk("reset/in_ready", 32'(in_ready), 32'd1);
    chk("reset/out_valid", 32'(out_valid), 32'd0);
    check_result("reset", 18'd0);
    run_op(16'h0000, 16'h0000, 1'b0, 1'b0, "zero");
    run_op(16'hFFFF, 16'h0001, 1'b0, 1'b0, "ripple");
    chk("ripple_const/sum", 32'(sum), 32'h0000);
    chk("ripple_const/cout", 32'(cout), 32'd1);
    run_op(16'h1234, 16'h4321, 1'b1, 1'b0, "cin1");
    chk("cin1_const/sum", 32'(sum), 32'h5556);
    run_op(16'h7FFF, 16'h0001, 1'b0, 1'b0, "pos_ovf");
    chk("pos_ovf_const/ovf", 32'(overflow), 32'd1);
    run_op(16'h8000, 16'h0001, 1'b0, 1'b1, "sub_ovf");
    chk("sub_ovf_const/sum", 32'(sum), 32'h7FFF);
    run_op(16'h0005, 16'h0007, 1'b0, 1'b1, "borrow_c0");
    run_op(16'h0005, 16'h0007, 1'b1, 1'b1, "borrow_c1");
    chk("borrow_c1_const/sum", 32'(sum), 32'hFFFE);
    chk("borrow_c1_const/cout", 32'(cout), 32'd0);
    // backpressure: hold DONE while new operands are offered
    a = 16'h1234; b = 16'h1111; cin = 1'b0; sub = 1'b0; in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    wait_valid(k);
    chk("bp/latency", 32'(k), 32'(N));
    e = ref_op(16'h1234, 16'h1111, 1'b0, 1'b0);
    a = 16'hAAAA; b = 16'h5555; cin = 1'b1; sub = 1'b0; in_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      step();
      chk("bp/out_valid_held", 32'(out_valid), 32'd1);
      chk("bp/in_ready_held", 32'(in_ready), 32'd0);
      check_result("bp_hold", e);
    end
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    chk("bp/idle_in_ready", 32'(in_ready), 32'd1);
    chk("bp/idle_out_valid", 32'(out_valid), 32'd0);
    step();
    in_valid = 1'b0;
    chk("bp/accepted", 32'(in_ready), 32'd0);
    wait_valid(k);
    chk("bp/new_latency", 32'(k), 32'(N));
    check_result("bp_new", ref_op(16'hAAAA, 16'h5555, 1'b1, 1'b0));
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    // abort mid-run with reset
    a = 16'hFFFF; b = 16'h0001; cin = 1'b0; sub = 1'b0; in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    step();
    step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("abort/out_valid", 32'(out_valid), 32'd0);
    chk("abort/in_ready", 32'(in_ready), 32'd1);
    chk("abort/sum", 32'(sum), 32'd0);
    chk("abort/cout", 32'(cout), 32'd0);
    run_op(16'h0001, 16'h0001, 1'b0, 1'b0, "after_abort");
    chk("after_abort_const/sum", 32'(sum), 32'h0002);
    for (int i = 0; i < 150; i++)
      run_op(16'($urandom), 16'($urandom), 1'($urandom), 1'($urandom), $sformatf("rand%0d", i));
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
